fp_dispatch_rob: RTL and testbench
==================================

FP_DISPATCH_ROB -- requirements
Module: fp_dispatch_rob

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set operand/result width.
REQ-002 Parameter NUM_UNITS, default 3, SHALL set the number of attached execution units (0=add/sub, 1=mul, 2=sin/cos by default).
REQ-003 Parameter ROB_DEPTH, default 4, SHALL set reorder-buffer entries; it is a power of two and at least 2.
REQ-004 Port list SHALL be:
- clk  in  1  single clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid&in_ready
- op1, op2  in  DATA_W  operands
- op_sel  in  3  unit select
- unit_start  out  NUM_UNITS  one-cycle start pulse per unit
- unit_op1, unit_op2  out  DATA_W  registered operands, shared by all units
- unit_done  in  NUM_UNITS  one-cycle completion pulse per unit
- unit_result  in  NUM_UNITS*DATA_W  unit k result at bits [k*DATA_W +: DATA_W]
- unit_overflow  in  NUM_UNITS  overflow per unit, sampled with unit_done
- out_valid  out  1  head result available
- out_ready  in  1  consumer takes result when out_valid&out_ready
- result  out  DATA_W  head result
- overflow  out  1  head overflow flag
- illegal  out  1  head entry came from an illegal op_sel
- occupancy  out  clog2(ROB_DEPTH)+1  entries allocated

Function
REQ-005 op_sel < NUM_UNITS SHALL be legal and target unit op_sel; any other value SHALL be illegal.
REQ-006 in_ready SHALL be 1 iff occupancy < ROB_DEPTH and (op_sel illegal or target unit has no outstanding operation); a pop in the same cycle SHALL NOT free space for a push.
REQ-007 On acceptance in cycle t the block SHALL allocate the ROB tail entry, advance tail (modulo ROB_DEPTH), and record the entry index as the target unit's outstanding tag.
REQ-008 For a legal op accepted in cycle t, unit_start[op_sel] SHALL pulse for exactly cycle t+1 with unit_op1/unit_op2 holding the accepted operands; the operands SHALL hold until the next acceptance.
REQ-009 An illegal op SHALL be written complete at allocation: result 0, overflow 0, illegal 1; no unit_start.
REQ-010 unit_done[k] while unit k is outstanding SHALL write unit_result slice k and unit_overflow[k] into the tagged entry, mark it complete, and clear unit k's outstanding flag at the clock edge; unit k is issuable again from the next cycle.
REQ-011 unit_done[k] with unit k not outstanding SHALL be ignored.
REQ-012 Multiple unit_done bits in one cycle SHALL all be captured.
REQ-013 out_valid SHALL be 1 iff the head entry is complete; result/overflow/illegal SHALL show the head entry and hold stable while out_valid&~out_ready.
REQ-014 Results SHALL leave in acceptance order regardless of completion order; minimum latency acceptance-to-out_valid is 3 cycles for a unit returning done in the cycle after start.
REQ-015 A pop SHALL advance head modulo ROB_DEPTH and clear the entry's complete bit; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-016 An illegal op accepted into an empty ROB SHALL set out_valid the next cycle.

Reset
REQ-017 n_rst low SHALL immediately clear head, tail, occupancy, all complete and outstanding flags, unit_start, out_valid, unit_op1/unit_op2, result, overflow and illegal to 0; in_ready SHALL read 1 during reset only per REQ-006 with occupancy 0.
REQ-018 Reset mid-operation SHALL discard all in-flight entries; unit_done pulses arriving after release SHALL be ignored per REQ-011.

Verification
REQ-019 Single add: op1=0x3F800000, op2=0x40000000, op_sel=0, unit 0 done 2 cycles after start with 0x40400000 -> out_valid with result 0x40400000, overflow 0, illegal 0.
REQ-020 Out-of-order: sin/cos op (unit 2, done after 10 cycles) then mul (unit 1, done after 1 cycle) -> mul result held until sin/cos result pops first.
REQ-021 Full: out_ready=0, 4 illegal ops (op_sel=7) -> occupancy 4, in_ready 0; one pop with in_valid held -> push accepted only the cycle after the pop.
REQ-022 Busy unit: second op_sel=1 while unit 1 outstanding -> in_ready 0 until cycle after unit_done[1]; op_sel=0 accepted meanwhile.
REQ-023 Wrap and simultaneous: 10 back-to-back ops with out_ready=1 and same-cycle unit_done[0]&unit_done[1] -> all results in order, pointers wrap, none lost.
REQ-024 Reset with 3 entries in flight, then stale unit_done[2] -> occupancy 0, out_valid stays 0.

Source files
------------

// File: rtl/fp_dispatch_rob.sv
// Dispatches FP operations to single-issue execution units and returns their
// results in acceptance order through a small reorder buffer.
module fp_dispatch_rob #(
  parameter int DATA_W    = 32,
  parameter int NUM_UNITS = 3,
  parameter int ROB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             op1,
  input  logic [DATA_W-1:0]             op2,
  input  logic [2:0]                    op_sel,
  output logic [NUM_UNITS-1:0]          unit_start,
  output logic [DATA_W-1:0]             unit_op1,
  output logic [DATA_W-1:0]             unit_op2,
  input  logic [NUM_UNITS-1:0]          unit_done,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result,
  input  logic [NUM_UNITS-1:0]          unit_overflow,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             result,
  output logic                          overflow,
  output logic                          illegal,
  output logic [$clog2(ROB_DEPTH):0]    occupancy
);

  localparam int AW = $clog2(ROB_DEPTH);
  localparam logic [AW:0] DEPTH_C = ROB_DEPTH[AW:0];

  logic [AW-1:0]        head, tail;
  logic [ROB_DEPTH-1:0] complete, complete_nxt;
  logic [NUM_UNITS-1:0] outstanding;
  logic [AW-1:0]        unit_tag [NUM_UNITS];
  logic [DATA_W-1:0]    rob_result [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rob_ovf, rob_ill;

  logic [NUM_UNITS-1:0] sel_onehot, done_hit;
  logic                 sel_legal, push, pop;

  // Decode: op_sel values beyond the attached units select nothing and are illegal
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < NUM_UNITS; k++)
      sel_onehot[k] = (32'(op_sel) == 32'(k));
  end

  assign sel_legal = |sel_onehot;
  assign in_ready  = (occupancy < DEPTH_C) && (!sel_legal || ~|(outstanding & sel_onehot));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign done_hit  = unit_done & outstanding;

  assign out_valid = complete[head];
  assign result    = out_valid ? rob_result[head] : '0;
  assign overflow  = out_valid & rob_ovf[head];
  assign illegal   = out_valid & rob_ill[head];

  always_comb begin
    complete_nxt = complete;
    if (pop)
      complete_nxt[head] = 1'b0;
    if (push && !sel_legal)
      complete_nxt[tail] = 1'b1;
    for (int k = 0; k < NUM_UNITS; k++)
      if (done_hit[k])
        complete_nxt[unit_tag[k]] = 1'b1;
  end

  // Control state: pointers, occupancy, issue bookkeeping and unit handshake
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      complete    <= '0;
      outstanding <= '0;
      unit_start  <= '0;
      unit_op1    <= '0;
      unit_op2    <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      complete    <= complete_nxt;
      outstanding <= (outstanding & ~done_hit) | ((push && sel_legal) ? sel_onehot : '0);
      unit_start  <= (push && sel_legal) ? sel_onehot : '0;
      if (push) begin
        unit_op1 <= op1;
        unit_op2 <= op2;
      end
    end
  end

  // Entry payload and per-unit tags; only ever read when qualified by control state
  always_ff @(posedge clk) begin
    if (push) begin
      rob_result[tail] <= '0;
      rob_ovf[tail]    <= 1'b0;
      rob_ill[tail]    <= !sel_legal;
    end
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (push && sel_onehot[k])
        unit_tag[k] <= tail;
      if (done_hit[k]) begin
        rob_result[unit_tag[k]] <= unit_result[k*DATA_W +: DATA_W];
        rob_ovf[unit_tag[k]]    <= unit_overflow[k];
      end
    end
  end

endmodule

// File: tb/tb_fp_dispatch_rob.sv
// Directed bench for fp_dispatch_rob; the execution units are played by the bench.
module tb_fp_dispatch_rob;
  localparam int DW = 32;
  localparam int NU = 3;
  localparam int RD = 4;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             in_valid, in_ready;
  logic [DW-1:0]    op1, op2;
  logic [2:0]       op_sel;
  logic [NU-1:0]    unit_start;
  logic [DW-1:0]    unit_op1, unit_op2;
  logic [NU-1:0]    unit_done;
  logic [NU*DW-1:0] unit_result;
  logic [NU-1:0]    unit_overflow;
  logic             out_valid, out_ready;
  logic [DW-1:0]    result;
  logic             overflow, illegal;
  logic [2:0]       occupancy;

  int n_cmp = 0;
  int n_fail = 0;

  fp_dispatch_rob #(.DATA_W(DW), .NUM_UNITS(NU), .ROB_DEPTH(RD)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .op_sel(op_sel), .unit_start(unit_start),
    .unit_op1(unit_op1), .unit_op2(unit_op2), .unit_done(unit_done),
    .unit_result(unit_result), .unit_overflow(unit_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .illegal(illegal), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic offer(input logic v, input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    in_valid = v; op_sel = s; op1 = a; op2 = b;
  endtask

  task automatic done_unit(input int k, input logic [DW-1:0] r, input logic ovf);
    unit_done[k] = 1'b1;
    unit_result[k*DW +: DW] = r;
    unit_overflow[k] = ovf;
  endtask

  task automatic clear_done;
    unit_done = '0;
    unit_overflow = '0;
  endtask

  function automatic logic [DW-1:0] opa(input int i);
    return 32'(32'h100 * i + 3);
  endfunction

  function automatic logic [DW-1:0] opb(input int i);
    return 32'(i + 7);
  endfunction

  task automatic test_reset;
    tick; #1;
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (unit_start !== 3'b000) begin n_fail++; $display("FAIL rst_start: got %b want 000", unit_start); end
    n_cmp++; if (result !== 32'h0 || illegal !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_head: got %h/%b/%b want 0/0/0", result, overflow, illegal); end
    n_cmp++; if (unit_op1 !== 32'h0 || unit_op2 !== 32'h0) begin n_fail++; $display("FAIL rst_ops: got %h %h want 0 0", unit_op1, unit_op2); end
    n_rst = 1'b1;
    tick;
  endtask

  task automatic test_single_add;
    offer(1, 3'd0, 32'h3F800000, 32'h40000000); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (unit_start !== 3'b001) begin n_fail++; $display("FAIL add_start: got %b want 001", unit_start); end
    n_cmp++; if (unit_op1 !== 32'h3F800000 || unit_op2 !== 32'h40000000) begin n_fail++; $display("FAIL add_ops: got %h %h want 3f800000 40000000", unit_op1, unit_op2); end
    tick; #1;
    n_cmp++; if (unit_start !== 3'b000) begin n_fail++; $display("FAIL add_start_pulse: got %b want 000", unit_start); end
    tick; done_unit(0, 32'h40400000, 1'b0); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
    tick; clear_done; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h40400000) begin n_fail++; $display("FAIL add_result: got %b/%h want 1/40400000", out_valid, result); end
    n_cmp++; if (overflow !== 1'b0 || illegal !== 1'b0 || occupancy !== 3'd1) begin n_fail++; $display("FAIL add_flags: got ovf %b ill %b occ %0d want 0 0 1", overflow, illegal, occupancy); end
    out_ready = 1'b1;
    tick; out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL add_pop: got %b/%0d want 0/0", out_valid, occupancy); end
    n_cmp++; if (unit_op1 !== 32'h3F800000) begin n_fail++; $display("FAIL add_op_hold: got %h want 3f800000", unit_op1); end
  endtask

  task automatic test_out_of_order;
    offer(1, 3'd2, 32'h1, 32'h2);
    tick; offer(1, 3'd1, 32'h5, 32'h6); #1;
    n_cmp++; if (unit_start !== 3'b100 || in_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_sin_start: got %b/%b want 100/1", unit_start, in_ready); end
    tick; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (unit_start !== 3'b010 || unit_op1 !== 32'h5) begin n_fail++; $display("FAIL ooo_mul_start: got %b/%h want 010/5", unit_start, unit_op1); end
    tick; done_unit(1, 32'h1111, 1'b1);
    tick; clear_done; #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd2) begin n_fail++; $display("FAIL ooo_mul_held: got %b/%0d want 0/2", out_valid, occupancy); end
    repeat (7) tick;
    done_unit(2, 32'h2222, 1'b0);
    tick; clear_done; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h2222 || overflow !== 1'b0) begin n_fail++; $display("FAIL ooo_first: got %b/%h/%b want 1/2222/0", out_valid, result, overflow); end
    tick; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h2222) begin n_fail++; $display("FAIL ooo_hold: got %b/%h want 1/2222", out_valid, result); end
    out_ready = 1'b1;
    tick; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h1111 || overflow !== 1'b1) begin n_fail++; $display("FAIL ooo_second: got %b/%h/%b want 1/1111/1", out_valid, result, overflow); end
    tick; out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL ooo_drain: got %b/%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_full;
    out_ready = 1'b0;
    offer(1, 3'd7, 32'hDEAD, 32'hBEEF); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_first_ready: got %b want 1", in_ready); end
    tick; #1;
    n_cmp++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_illegal_head: got %b/%b/%h/%b want 1/1/0/0", out_valid, illegal, result, overflow); end
    n_cmp++; if (unit_start !== 3'b000) begin n_fail++; $display("FAIL full_no_start: got %b want 000", unit_start); end
    tick; tick; tick; #1;
    n_cmp++; if (occupancy !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_occ: got %0d/%b want 4/0", occupancy, in_ready); end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_space: got %b want 0", in_ready); end
    tick; out_ready = 1'b0; #1;
    n_cmp++; if (occupancy !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got %0d/%b want 3/1", occupancy, in_ready); end
    tick; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_refill: got %0d want 4", occupancy); end
    out_ready = 1'b1;
    tick; #1;
    n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL full_pop_occ: got %0d want 3", occupancy); end
    offer(1, 3'd7, 32'h1, 32'h1);
    tick; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL full_push_pop: got %0d want 3", occupancy); end
    repeat (3) tick;
    out_ready = 1'b0; #1;
    n_cmp++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: got %0d/%b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_busy_unit;
    offer(1, 3'd1, 32'h10, 32'h20);
    tick; offer(1, 3'd1, 32'h11, 32'h21); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_block: got %b want 0", in_ready); end
    offer(1, 3'd0, 32'h30, 32'h40); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_other_unit: got %b want 1", in_ready); end
    tick; offer(1, 3'd1, 32'h33, 32'h44); done_unit(1, 32'hA1, 1'b0); #1;
    n_cmp++; if (unit_start !== 3'b001 || in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_done_cycle: got %b/%b want 001/0", unit_start, in_ready); end
    tick; clear_done; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_release: got %b want 1", in_ready); end
    tick; offer(0, 3'd0, 32'h0, 32'h0); done_unit(0, 32'hA0, 1'b0); #1;
    n_cmp++; if (unit_start !== 3'b010 || unit_op1 !== 32'h33) begin n_fail++; $display("FAIL busy_reissue: got %b/%h want 010/33", unit_start, unit_op1); end
    tick; clear_done; done_unit(1, 32'hA2, 1'b1);
    tick; clear_done; out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hA1) begin n_fail++; $display("FAIL busy_out0: got %b/%h want 1/a1", out_valid, result); end
    tick; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hA0) begin n_fail++; $display("FAIL busy_out1: got %b/%h want 1/a0", out_valid, result); end
    tick; #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hA2 || overflow !== 1'b1) begin n_fail++; $display("FAIL busy_out2: got %b/%h/%b want 1/a2/1", out_valid, result, overflow); end
    tick; out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL busy_drain: got %b/%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int d0_at = -1;
    int d1_at = -1;
    logic [DW-1:0] d0_v = '0;
    logic [DW-1:0] d1_v = '0;
    logic [DW-1:0] exp_r;
    out_ready = 1'b1;
    while (got < 10 && cyc < 200) begin
      clear_done;
      if (cyc == d0_at) done_unit(0, d0_v, 1'b0);
      if (cyc == d1_at) done_unit(1, d1_v, 1'b1);
      if (idx < 10) offer(1, 3'(idx % 2), opa(idx), opb(idx));
      else offer(0, 3'd0, 32'h0, 32'h0);
      #1;
      if (unit_start[0]) begin d0_at = cyc + 2; d0_v = unit_op1 + unit_op2; end
      if (unit_start[1]) begin d1_at = cyc + 1; d1_v = unit_op1 ^ unit_op2; end
      if (out_valid) begin
        exp_r = (got % 2 == 0) ? opa(got) + opb(got) : opa(got) ^ opb(got);
        n_cmp++;
        if (result !== exp_r || overflow !== 1'(got % 2) || illegal !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h/%b/%b want %h/%b/0", got, result, overflow, illegal, exp_r, 1'(got % 2));
        end
        got++;
      end
      if (in_valid && in_ready) idx++;
      tick;
      cyc++;
    end
    n_cmp++; if (got != 10) begin n_fail++; $display("FAIL b2b_count: got %0d results want 10", got); end
    clear_done; out_ready = 1'b0; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0d/%b want 0/0", occupancy, out_valid); end
  endtask

  task automatic test_reset_midflight;
    offer(1, 3'd2, 32'h7, 32'h8);
    tick; offer(1, 3'd0, 32'h9, 32'hA);
    tick; offer(1, 3'd1, 32'hB, 32'hC);
    tick; offer(0, 3'd0, 32'h0, 32'h0); #1;
    n_cmp++; if (occupancy !== 3'd3 || unit_start !== 3'b010) begin n_fail++; $display("FAIL mid_inflight: got %0d/%b want 3/010", occupancy, unit_start); end
    n_rst = 1'b0; #1;
    n_cmp++; if (occupancy !== 3'd0 || unit_start !== 3'b000 || unit_op1 !== 32'h0) begin n_fail++; $display("FAIL mid_async_clear: got %0d/%b/%h want 0/000/0", occupancy, unit_start, unit_op1); end
    tick; n_rst = 1'b1;
    tick; done_unit(2, 32'h5555, 1'b1);
    tick; clear_done; #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_stale_done: got %b/%0d want 0/0", out_valid, occupancy); end
    offer(1, 3'd2, 32'h1, 32'h1); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_unit_free: got %b want 1", in_ready); end
    offer(0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    n_rst = 1'b0;
    in_valid = 1'b0; op_sel = 3'd0; op1 = '0; op2 = '0;
    unit_done = '0; unit_result = '0; unit_overflow = '0;
    out_ready = 1'b0;
    test_reset;
    test_single_add;
    test_out_of_order;
    test_full;
    test_busy_unit;
    test_back_to_back;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
